// File: rtl/iob_pcie_chnl_rx.sv
// RIFFA receive-channel adapter: accepts one host transaction at a time and
// forwards its beats through a first-word-fall-through FIFO as a valid/ready stream.
module iob_pcie_chnl_rx #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int FIFO_AW          = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN,
  output logic [C_PCI_DATA_WIDTH-1:0] OUT_DATA,
  output logic                        OUT_VALID,
  output logic                        OUT_LAST,
  input  logic                        OUT_READY,
  output logic [31:0]                 STAT_LEN,
  output logic [30:0]                 STAT_OFF,
  output logic                        STAT_LASTTX,
  output logic [31:0]                 STAT_WORDS,
  output logic                        RX_DONE,
  output logic                        ERR_LEN,
  input  logic                        ERR_CLR
);

  localparam int          DW    = C_PCI_DATA_WIDTH;
  localparam int          DEPTH = 1 << FIFO_AW;
  localparam logic [31:0] W     = 32'(C_PCI_DATA_WIDTH / 32);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_RECV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       len_q, len_d;
  logic [30:0]       off_q, off_d;
  logic              lasttx_q, lasttx_d;
  logic [31:0]       words_q, words_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [FIFO_AW:0]  wptr_q, rptr_q;
  logic [DW:0]       mem [DEPTH];

  logic full, empty, covered, accept, push, pop, last_flag, err_set;

  assign CHNL_RX_CLK = CLK;

  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  // Once the announced length is covered, further beats are drained and dropped
  // so a misbehaving host can never stall on a full FIFO.
  assign covered          = (words_q >= len_q);
  assign CHNL_RX_DATA_REN = (state_q == S_RECV) && (!full || covered);
  assign accept           = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
  assign push             = accept && !covered && !full;
  assign pop              = !empty && OUT_READY;
  assign last_flag        = ({1'b0, words_q} + {1'b0, W}) >= {1'b0, len_q};

  // State register and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      off_q    <= '0;
      lasttx_q <= 1'b0;
      words_q  <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      off_q    <= off_d;
      lasttx_q <= lasttx_d;
      words_q  <= words_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr_q[FIFO_AW-1:0]] <= {last_flag, CHNL_RX_DATA};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (CHNL_RX) state_d = S_ACK;
      S_ACK:   state_d = S_RECV;
      S_RECV:  if (!CHNL_RX && !accept) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / status next values; ACK and RX_DONE are registered from state_d so
  // they line up exactly with the ACK and DONE states.
  always_comb begin
    len_d    = len_q;
    off_d    = off_q;
    lasttx_d = lasttx_q;
    words_d  = words_q;
    ack_d    = (state_d == S_ACK);
    done_d   = (state_d == S_DONE);
    if (state_q == S_IDLE && CHNL_RX) begin
      len_d    = CHNL_RX_LEN;
      off_d    = CHNL_RX_OFF;
      lasttx_d = CHNL_RX_LAST;
      words_d  = '0;
    end
    if (accept) words_d = words_q + W;
    err_set = (accept && covered) || (state_q == S_DONE && !covered);
    err_d   = err_set || (err_q && !ERR_CLR);
  end

  assign OUT_VALID   = !empty;
  assign OUT_DATA    = mem[rptr_q[FIFO_AW-1:0]][DW-1:0];
  assign OUT_LAST    = mem[rptr_q[FIFO_AW-1:0]][DW];
  assign CHNL_RX_ACK = ack_q;
  assign RX_DONE     = done_q;
  assign ERR_LEN     = err_q;
  assign STAT_LEN    = len_q;
  assign STAT_OFF    = off_q;
  assign STAT_LASTTX = lasttx_q;
  assign STAT_WORDS  = words_q;

endmodule

// File: tb/tb_iob_pcie_chnl_rx.sv
// Directed bench for iob_pcie_chnl_rx: a 32-bit instance with a 4-deep FIFO and
// a 64-bit instance, driven by a shared host model.
module tb_iob_pcie_chnl_rx;

  logic        CLK = 1'b0;
  logic        RST;
  logic        rx, rx_last, rx_valid, out_ready, err_clr;
  logic [31:0] rx_len;
  logic [30:0] rx_off;
  logic [63:0] hdata;
  logic        sel;

  logic        a_clk, a_ack, a_ren, a_ov, a_ol, a_lasttx, a_done, a_err;
  logic [31:0] a_od, a_len, a_words;
  logic [30:0] a_off;
  logic        b_clk, b_ack, b_ren, b_ov, b_ol, b_lasttx, b_done, b_err;
  logic [63:0] b_od;
  logic [31:0] b_len, b_words;
  logic [30:0] b_off;

  int checks = 0;
  int errors = 0;
  int a_ack_cnt = 0, a_done_cnt = 0, b_done_cnt = 0;
  logic [63:0] qa_d[$], qb_d[$];
  logic        qa_l[$], qb_l[$];

  always #5 CLK = ~CLK;

  iob_pcie_chnl_rx #(.C_PCI_DATA_WIDTH(32), .FIFO_AW(2)) dut_a (
    .CLK(CLK), .RST(RST), .CHNL_RX_CLK(a_clk), .CHNL_RX(rx), .CHNL_RX_ACK(a_ack),
    .CHNL_RX_LAST(rx_last), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(rx_off),
    .CHNL_RX_DATA(hdata[31:0]), .CHNL_RX_DATA_VALID(rx_valid), .CHNL_RX_DATA_REN(a_ren),
    .OUT_DATA(a_od), .OUT_VALID(a_ov), .OUT_LAST(a_ol), .OUT_READY(out_ready),
    .STAT_LEN(a_len), .STAT_OFF(a_off), .STAT_LASTTX(a_lasttx), .STAT_WORDS(a_words),
    .RX_DONE(a_done), .ERR_LEN(a_err), .ERR_CLR(err_clr));

  iob_pcie_chnl_rx #(.C_PCI_DATA_WIDTH(64), .FIFO_AW(4)) dut_b (
    .CLK(CLK), .RST(RST), .CHNL_RX_CLK(b_clk), .CHNL_RX(rx), .CHNL_RX_ACK(b_ack),
    .CHNL_RX_LAST(rx_last), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(rx_off),
    .CHNL_RX_DATA(hdata), .CHNL_RX_DATA_VALID(rx_valid), .CHNL_RX_DATA_REN(b_ren),
    .OUT_DATA(b_od), .OUT_VALID(b_ov), .OUT_LAST(b_ol), .OUT_READY(out_ready),
    .STAT_LEN(b_len), .STAT_OFF(b_off), .STAT_LASTTX(b_lasttx), .STAT_WORDS(b_words),
    .RX_DONE(b_done), .ERR_LEN(b_err), .ERR_CLR(err_clr));

  // Stream collector and pulse counters, sampled mid-cycle
  always @(negedge CLK) begin
    if (a_ov && out_ready) begin
      qa_d.push_back({32'h0, a_od});
      qa_l.push_back(a_ol);
    end
    if (b_ov && out_ready) begin
      qb_d.push_back(b_od);
      qb_l.push_back(b_ol);
    end
    if (a_ack)  a_ack_cnt  <= a_ack_cnt + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Host side of one transaction; hold keeps CHNL_RX asserted afterwards.
  task automatic send(input logic [31:0] len, input int nb, input logic [63:0] base,
                      input logic hold);
    int i = 0;
    int t = 0;
    logic got_ack = 1'b0;
    rx = 1'b1; rx_len = len; rx_off = 31'h55; rx_last = 1'b1;
    for (int k = 0; k < 20 && !got_ack; k++) begin
      @(negedge CLK);
      got_ack = sel ? b_ack : a_ack;
    end
    if (!got_ack) begin
      check("ack_timeout", 64'(got_ack), 64'd1);
      rx = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    while (i < nb && t < 400) begin
      hdata = base + 64'(i); rx_valid = 1'b1;
      @(negedge CLK);
      t++;
      if (sel ? b_ren : a_ren) i++;
      @(posedge CLK); #1;
    end
    if (i < nb) check("beat_timeout", 64'(i), 64'(nb));
    rx_valid = 1'b0;
    if (!hold) rx = 1'b0;
  endtask

  task automatic check_seq_a(input string tag, input int s, input int n,
                             input logic [63:0] base, input int last_at);
    check({tag, "_cnt"}, 64'(qa_d.size() - s), 64'(n));
    for (int k = 0; k < n && s + k < qa_d.size(); k++) begin
      check({tag, "_data"}, qa_d[s+k], base + 64'(k));
      check({tag, "_last"}, 64'(qa_l[s+k]), 64'(k == last_at));
    end
  endtask

  task automatic clear_err();
    @(posedge CLK); #1 err_clr = 1'b1;
    @(posedge CLK); #1 err_clr = 1'b0;
    check("err_clr", 64'(a_err), 64'd0);
  endtask

  initial begin
    int s, a0, d0;
    RST = 1'b1; rx = 1'b0; rx_last = 1'b0; rx_valid = 1'b0; out_ready = 1'b0;
    err_clr = 1'b0; rx_len = '0; rx_off = '0; hdata = '0; sel = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ack", 64'(a_ack), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_len", 64'(a_len), 64'd0);
    check("rst_words", 64'(a_words), 64'd0);
    check("rst_ov", 64'(a_ov), 64'd0);
    check("rst_ren", 64'(a_ren), 64'd0);
    check("rxclk", 64'(a_clk), 64'(CLK));
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    // Basic 4-word transaction
    out_ready = 1'b1; s = qa_d.size(); a0 = a_ack_cnt; d0 = a_done_cnt;
    send(32'd4, 4, 64'hA, 1'b0);
    repeat (8) @(negedge CLK);
    check_seq_a("t1", s, 4, 64'hA, 3);
    check("t1_ackpulse", 64'(a_ack_cnt - a0), 64'd1);
    check("t1_donepulse", 64'(a_done_cnt - d0), 64'd1);
    check("t1_words", 64'(a_words), 64'd4);
    check("t1_err", 64'(a_err), 64'd0);
    check("t1_len", 64'(a_len), 64'd4);
    check("t1_off", 64'(a_off), 64'h55);
    check("t1_lasttx", 64'(a_lasttx), 64'd1);

    // Backpressure: 4-deep FIFO fills, REN drops until the stream is drained
    out_ready = 1'b0; s = qa_d.size();
    fork
      send(32'd8, 8, 64'h10, 1'b0);
      begin
        repeat (12) @(negedge CLK);
        check("t2_ren_stall", 64'(a_ren), 64'd0);
        check("t2_ov_full", 64'(a_ov), 64'd1);
        check("t2_none_out", 64'(qa_d.size() - s), 64'd0);
        out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge CLK);
    check_seq_a("t2", s, 8, 64'h10, 7);
    check("t2_words", 64'(a_words), 64'd8);
    check("t2_err", 64'(a_err), 64'd0);

    // Overrun: 5 beats for LEN=3
    s = qa_d.size();
    send(32'd3, 5, 64'h20, 1'b0);
    repeat (8) @(negedge CLK);
    check_seq_a("t3", s, 3, 64'h20, 2);
    check("t3_words", 64'(a_words), 64'd5);
    check("t3_err", 64'(a_err), 64'd1);
    clear_err();

    // Underrun: host quits after 4 of 6 words
    s = qa_d.size(); d0 = a_done_cnt;
    send(32'd6, 4, 64'h30, 1'b0);
    repeat (8) @(negedge CLK);
    check_seq_a("t4", s, 4, 64'h30, -1);
    check("t4_donepulse", 64'(a_done_cnt - d0), 64'd1);
    check("t4_words", 64'(a_words), 64'd4);
    check("t4_err", 64'(a_err), 64'd1);
    clear_err();

    // Zero length: everything is overrun
    s = qa_d.size();
    send(32'd0, 2, 64'h40, 1'b0);
    repeat (8) @(negedge CLK);
    check("t5_cnt", 64'(qa_d.size() - s), 64'd0);
    check("t5_err", 64'(a_err), 64'd1);
    check("t5_words", 64'(a_words), 64'd2);
    clear_err();

    // 64-bit channel, LEN=3 words in 2 beats (partial final beat)
    sel = 1'b1; s = qb_d.size(); d0 = b_done_cnt;
    send(32'd3, 2, 64'h1111_0000_2222_0000, 1'b0);
    repeat (8) @(negedge CLK);
    check("t6_cnt", 64'(qb_d.size() - s), 64'd2);
    if (qb_d.size() >= s + 2) begin
      check("t6_d0", qb_d[s], 64'h1111_0000_2222_0000);
      check("t6_d1", qb_d[s+1], 64'h1111_0000_2222_0001);
      check("t6_l0", 64'(qb_l[s]), 64'd0);
      check("t6_l1", 64'(qb_l[s+1]), 64'd1);
    end
    check("t6_words", 64'(b_words), 64'd4);
    check("t6_err", 64'(b_err), 64'd0);
    check("t6_done", 64'(b_done_cnt - d0), 64'd1);
    check("t6_off", 64'(b_off), 64'h55);
    check("t6_lasttx", 64'(b_lasttx), 64'd1);
    check("t6_len", 64'(b_len), 64'd3);
    check("t6_rxclk", 64'(b_clk), 64'(CLK));
    sel = 1'b0;

    // Asynchronous reset mid-transaction with queued data
    out_ready = 1'b0;
    send(32'd4, 2, 64'h50, 1'b1);
    #2;
    check("t7_pre_ov", 64'(a_ov), 64'd1);
    RST = 1'b1; rx = 1'b0;
    #1;
    check("t7_ov", 64'(a_ov), 64'd0);
    check("t7_words", 64'(a_words), 64'd0);
    check("t7_len", 64'(a_len), 64'd0);
    check("t7_off", 64'(a_off), 64'd0);
    check("t7_lasttx", 64'(a_lasttx), 64'd0);
    check("t7_err", 64'(a_err), 64'd0);
    check("t7_ack", 64'(a_ack), 64'd0);
    check("t7_done", 64'(a_done), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    a0 = a_ack_cnt;
    repeat (3) @(negedge CLK);
    check("t7_idle", 64'(a_ack_cnt - a0), 64'd0);
    check("t7_ov_after", 64'(a_ov), 64'd0);
    out_ready = 1'b1; s = qa_d.size();
    send(32'd2, 2, 64'h60, 1'b0);
    repeat (8) @(negedge CLK);
    check_seq_a("t7", s, 2, 64'h60, 1);
    check("t7_err_end", 64'(a_err), 64'd0);
    check("t7_words_end", 64'(a_words), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
